// File: rtl/four_bit_arb_pkg.sv
// Shared constants and state type for the 8-way round-robin 4-bit arbiter.
package four_bit_arb_pkg;
  localparam int NREQ    = 8;
  localparam int ID_W    = 3;
  localparam int DW      = 4;
  localparam int BURST_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;
endpackage

// File: rtl/four_bit_rr_arbiter_if.sv
// Request/data bus from the 8 producers plus the valid/ready output channel.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface four_bit_rr_arbiter_if;
  import four_bit_arb_pkg::*;

  logic [NREQ-1:0]    req;
  logic [0:NREQ*DW-1] w;
  logic               out_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [ID_W-1:0]    out_id;
  logic [NREQ-1:0]    gnt;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif

  modport master (
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  req, w, out_ready,
    output out_valid, out_data, out_id, gnt
  );

  modport slave (
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output req, w, out_ready,
    input  out_valid, out_data, out_id, gnt
  );
endinterface

// File: rtl/four_bit_mux8to1.sv
// Selects requester s's word from the MSB-first packed bus (w[4s:4s+3]).
// Combinational; no backpressure.
module four_bit_mux8to1 (
  input  logic [0:31] w,
  input  logic [2:0]  s,
  output logic [3:0]  f
);
  always_comb f = w[{s, 2'b00} +: 4];
endmodule

// File: rtl/rr_pick8.sv
// Circular first-set search over 8 requests starting at ptr.
// Purely combinational; no backpressure.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       any,
  output logic [2:0] idx
);
  logic [2:0] w_cand;

  always_comb begin
    any    = 1'b0;
    idx    = 3'd0;
    w_cand = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_cand = ptr + 3'(i);
      if (!any && req[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end
endmodule

// File: rtl/four_bit_rr_arbiter.sv
// Round-robin arbiter: grants one of 8 requesters and holds its 4-bit word on valid/ready.
// Latency: req sampled at edge N -> out_valid after edge N; one IDLE bubble per word.
// Backpressure: word held stable while out_ready=0; optional ARB_LOCK_EN adds bubble-free bursts.
module four_bit_rr_arbiter #(
  parameter int DW        = 4,
  parameter int PTR_INIT  = 0,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  four_bit_rr_arbiter_if.master  bus
);
  import four_bit_arb_pkg::*;

  if (DW != 4 || PTR_INIT < 0 || PTR_INIT > 7 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_cfg
    $error("four_bit_rr_arbiter: unsupported parameter set");
  end

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_out_id;
  logic [DW-1:0]    r_out_data;

  logic             w_any;
  logic [ID_W-1:0]  w_pick;
  logic [ID_W-1:0]  w_sel;
  logic [DW-1:0]    w_word;
  logic             w_hs;
  logic             w_extend;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  // In HOLD the mux follows the granted id so a locked burst can recapture its next word.
  assign w_sel = (r_state == HOLD) ? r_out_id : w_pick;

  four_bit_mux8to1 u_mux (
    .w (bus.w),
    .s (w_sel),
    .f (w_word)
  );

  assign w_hs = (r_state == HOLD) && bus.out_ready;

`ifdef ARB_LOCK_EN
  logic [BURST_W-1:0] r_burst;

  assign w_extend = w_hs && bus.lock[r_out_id] && bus.req[r_out_id]
                    && (r_burst < BURST_W'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else if (w_extend) begin
      r_burst <= r_burst + 1'b1;
    end else if (w_hs) begin
      r_burst <= '0;
    end
  end
`else
  assign w_extend = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= ID_W'(PTR_INIT);
      r_out_id   <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_out_id   <= w_pick;
            r_out_data <= w_word;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (w_extend) begin
            r_out_data <= w_word;
          end else if (w_hs) begin
            r_ptr   <= r_out_id + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign bus.gnt       = w_hs ? (NREQ'(1) << r_out_id) : '0;
endmodule

// File: tb/tb_four_bit_rr_arbiter.sv
// Directed bench for four_bit_rr_arbiter: round-robin order, backpressure, wrap, idle, async reset.
// Requester k's word is k+1 unless a vector overrides it.
module tb_four_bit_rr_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  four_bit_rr_arbiter_if bus();

  four_bit_rr_arbiter #(.DW(4), .PTR_INIT(0), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input int id, input int data, input int gnt);
    check({tag, "_vld"},  32'(bus.out_valid), 32'd1);
    check({tag, "_id"},   32'(bus.out_id),    32'(id));
    check({tag, "_data"}, 32'(bus.out_data),  32'(data));
    check({tag, "_gnt"},  32'(bus.gnt),       32'(gnt));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_gnt"}, 32'(bus.gnt),       32'd0);
  endtask

  initial begin
    bus.req       = 8'hFF;
    bus.w         = 32'h12345678;
    bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock      = 8'h00;
`endif

    // Reset held across a rising edge with all requests up.
    @(negedge clk);
    expect_idle("rst");
    bus.out_ready = 1'b1;
    #1 check("rst_rdy_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous requesters: ids 0..7 then 0, one word every 2 cycles.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      expect_word($sformatf("rr%0d", i), i % 8, (i % 8) + 1, 1 << (i % 8));
      @(negedge clk);
      expect_idle($sformatf("rr_bub%0d", i));
    end
    bus.req = 8'h00;

    // Backpressure on requester 3; w changes mid-hold must not leak through.
    bus.out_ready = 1'b0;
    bus.req       = 8'h08;
    bus.w[12:15]  = 4'hA;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expect_word($sformatf("bp%0d", c), 3, 4'hA, 0);
      if (c == 2) bus.w[12:15] = 4'h5;
    end
    bus.out_ready = 1'b1;
    #1 check("bp_gnt", 32'(bus.gnt), 32'h08);
    @(posedge clk);
    #1 bus.req = 8'h40;
    @(negedge clk);
    expect_idle("bp_rel");

    // Serve 6 so the pointer lands on 7, then 7 and 0 both request.
    @(negedge clk);
    expect_word("six", 6, 7, 8'h40);
    @(posedge clk);
    #1 bus.req = 8'h81;
    @(negedge clk);
    expect_idle("wrap_bub0");
    @(negedge clk);
    expect_word("wrap7", 7, 8, 8'h80);
    @(posedge clk);
    #1 bus.req = 8'h01;
    @(negedge clk);
    expect_idle("wrap_bub1");
    @(negedge clk);
    expect_word("wrap0", 0, 1, 8'h01);
    @(posedge clk);
    #1 bus.req = 8'h00;

    // Idle: nothing happens and the pointer stays at 1.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      expect_idle($sformatf("idle%0d", c));
    end
    bus.req = 8'hFF;
    @(negedge clk);
    expect_word("idle_ptr", 1, 2, 8'h02);
    @(posedge clk);
    #1 begin
      bus.req       = 8'h20;
      bus.out_ready = 1'b0;
    end
    @(negedge clk);
    expect_idle("pre5");
    @(negedge clk);
    expect_word("hold5", 5, 6, 0);

    // Asynchronous reset mid-hold drops the word without a grant.
    #2 rst_n = 1'b0;
    #1 begin
      expect_idle("arst");
      check("arst_id", 32'(bus.out_id), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.req       = 8'hFF;
    #1 check("arst_rdy_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_word("post_rst", 0, 1, 8'h01);

`ifdef ARB_LOCK_EN
    // Locked burst: 4 bubble-free words from id 2, then id 4.
    @(posedge clk);
    #1 begin
      bus.req  = 8'h14;
      bus.lock = 8'h04;
    end
    @(negedge clk);
    expect_idle("lk_pre");
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      expect_word($sformatf("lk%0d", b), 2, 3, 8'h04);
    end
    @(posedge clk);
    #1 begin
      bus.req  = 8'h10;
      bus.lock = 8'h00;
    end
    @(negedge clk);
    expect_idle("lk_bub");
    @(negedge clk);
    expect_word("lk_next", 4, 5, 8'h10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
